prime_ram_arbiter: RTL and testbench
====================================

# prime_ram_arbiter

Shares the 1-bit prime-flag RAM between the sieve engine and the result scanner. The sieve writes composite flags and reads candidate flags; the scanner reads flags while counting up or down. Read requests are arbitrated round-robin, and each returned read is tagged back to its owner through a fixed-latency tag pipeline. A read-during-write hazard on the same address is blocked. The block sits between the sieve/scanner logic and the simple dual-port RAM IP.

## Interface
Parameters:
- AW, 20, address width of the flag RAM
- RD_LAT, 2, RAM read latency in clocks from ram_raddr to valid ram_rdata (legal range 1..4)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- s_rreq  in  1  sieve read request, held with s_raddr stable until granted
- s_raddr  in  AW  sieve read address
- s_rgnt  out  1  sieve read granted this cycle (combinational)
- s_rvalid  out  1  sieve read data valid
- s_rdata  out  1  sieve read data
- s_wreq  in  1  sieve write request
- s_waddr  in  AW  sieve write address
- s_wdata  in  1  sieve write data
- s_wgnt  out  1  write accepted; equals s_wreq & ~reset
- c_rreq  in  1  scanner read request, same rules as s_rreq
- c_raddr  in  AW  scanner read address
- c_rgnt  out  1  scanner read granted this cycle (combinational)
- c_rvalid  out  1  scanner read data valid
- c_rdata  out  1  scanner read data
- ram_wea  out  1  RAM write enable (registered)
- ram_waddr  out  AW  RAM write address (registered)
- ram_wdata  out  1  RAM write data (registered)
- ram_raddr  out  AW  RAM read address (registered)
- ram_rdata  in  1  RAM read data
- busy  out  1  at least one read in flight

## Operation
- A read transfer happens when a requester's req and gnt are both high in the same cycle. A write transfer happens when s_wreq and s_wgnt are both high.
- Writes are never blocked. The granted write is registered onto ram_wea/ram_waddr/ram_wdata in the next cycle. ram_wea is low in any cycle that follows a cycle with no write transfer.
- Read arbitration state is a 1-bit last-grant pointer lg (0 = sieve, 1 = scanner). Reset sets lg to 1, so the sieve wins the first contention.
  - Only one requester eligible: it is granted.
  - Both eligible: the requester that was not granted last is granted.
  - lg updates only on a grant.
- Hazard: a read is ineligible in any cycle where s_wreq=1 and its address equals s_waddr. Its gnt is 0 and the request must be held.
  - If the sieve is hazard-blocked and the scanner is not, the scanner is granted.
- The granted address is registered to ram_raddr. ram_raddr holds its value when there is no grant.
- Tag pipeline: RD_LAT+1 stages, each holding {valid, owner}. A grant enters stage 0; the last stage drives the outputs:
  - s_rvalid = valid & owner==0
  - c_rvalid = valid & owner==1
- Data routing: s_rdata = ram_rdata when s_rvalid, else 0; c_rdata likewise.
- busy = OR of all tag valid bits.
- Reset mid-operation: all tag stages are cleared and in-flight reads are dropped. No rvalid is produced for reads granted before reset.

## Timing
- Reset values: all gnt, rvalid, rdata, ram_wea and busy are 0; ram_waddr and ram_raddr are 0; ram_wdata is 0. No grant is issued during a reset cycle.
- Read granted in cycle t:
  - ram_raddr holds the address in cycle t+1.
  - Matching rvalid/rdata appear in exactly cycle t+RD_LAT+1, for one cycle.
- Throughput: one read grant per cycle with back-to-back rvalid; no bubbles are required.
- Write granted in cycle t: ram_wea=1 in cycle t+1 and the RAM is updated at the end of t+1. A read of that address granted at t+1 or later returns the new value.
- Fairness: with no hazards, a held request is granted within 2 cycles of assertion.
- Response order across both requesters equals grant order.

## Test plan
- Reset with RD_LAT=2: hold s_rreq=1 during reset -> s_rgnt=0, busy=0; first grant occurs in the first cycle after reset deasserts.
- Single sieve read of 0x00007 with flag=1 granted at cycle 10 -> ram_raddr=0x00007 at cycle 11; s_rvalid=1, s_rdata=1 at cycle 13; c_rvalid stays 0.
- Both requesters held for 4 cycles after reset -> grants in order S,C,S,C; rvalids follow in the same order 3 cycles later.
- s_wreq with s_waddr=0x00009, s_wdata=1 in the same cycle as c_rreq with c_raddr=0x00009 -> c_rgnt=0 that cycle; granted next cycle; c_rdata=1.
- Sieve hazard-blocked (s_raddr=s_waddr) while scanner requests -> c_rgnt=1 and s_rgnt=0 even though lg favors the sieve.
- Assert reset for one cycle while 2 reads are in flight -> no rvalid is ever produced for them; busy=0 in the cycle after reset.

Source files
------------

// File: rtl/prime_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : prime_ram_arbiter_if
//  Description : Bundles the sieve read/write channel, the scanner read
//                channel and the simple dual-port flag RAM port into one
//                interface.
//                slave  modport : used by the arbiter.
//                master modport : used by the surrounding logic/RAM.
//  Ports       : s_* sieve channel, c_* scanner channel, ram_* RAM port,
//                busy (reads in flight).
//  Revision    : 1.0 - initial release
// ============================================================================
interface prime_ram_arbiter_if #(
  parameter int AW = 20
);
  // Sieve channel
  logic          s_rreq;
  logic [AW-1:0] s_raddr;
  logic          s_rgnt;
  logic          s_rvalid;
  logic          s_rdata;
  logic          s_wreq;
  logic [AW-1:0] s_waddr;
  logic          s_wdata;
  logic          s_wgnt;
  // Scanner channel
  logic          c_rreq;
  logic [AW-1:0] c_raddr;
  logic          c_rgnt;
  logic          c_rvalid;
  logic          c_rdata;
  // RAM port
  logic          ram_wea;
  logic [AW-1:0] ram_waddr;
  logic          ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic          ram_rdata;
  // Status
  logic          busy;

  modport slave (
    input  s_rreq, s_raddr, s_wreq, s_waddr, s_wdata,
    input  c_rreq, c_raddr, ram_rdata,
    output s_rgnt, s_rvalid, s_rdata, s_wgnt,
    output c_rgnt, c_rvalid, c_rdata,
    output ram_wea, ram_waddr, ram_wdata, ram_raddr, busy
  );

  modport master (
    output s_rreq, s_raddr, s_wreq, s_waddr, s_wdata,
    output c_rreq, c_raddr, ram_rdata,
    input  s_rgnt, s_rvalid, s_rdata, s_wgnt,
    input  c_rgnt, c_rvalid, c_rdata,
    input  ram_wea, ram_waddr, ram_wdata, ram_raddr, busy
  );
endinterface
`default_nettype wire

// File: rtl/prime_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : prime_ram_arbiter
//  Description : Shares the 1-bit prime-flag RAM between the sieve engine
//                and the result scanner. Round-robin read arbitration with
//                a read-during-write hazard block, registered RAM port and
//                a fixed-latency tag pipeline routing read data back to
//                its owner.
//  Ports       : clk   - system clock, rising edge
//                reset - synchronous active-high reset
//                bus   - prime_ram_arbiter_if.slave (sieve, scanner, RAM)
//  Revision    : 1.0 - initial release
// ============================================================================
module prime_ram_arbiter #(
  parameter int AW     = 20,
  parameter int RD_LAT = 2
) (
  input  wire logic            clk,
  input  wire logic            reset,
  prime_ram_arbiter_if.slave   bus
);

  // One tag stage per clock between grant and data return.
  localparam int c_NSTG = RD_LAT + 1;

  // Registered state
  logic              r_lg;       // last grant: 0 = sieve, 1 = scanner
  logic              r_wea;
  logic [AW-1:0]     r_waddr;
  logic              r_wdata;
  logic [AW-1:0]     r_raddr;
  logic [c_NSTG-1:0] r_tag_v;    // bit 0 = newest stage
  logic [c_NSTG-1:0] r_tag_o;    // owner per stage: 1 = scanner

  // Combinational arbitration
  logic w_s_haz;
  logic w_c_haz;
  logic w_s_elig;
  logic w_c_elig;
  logic w_s_gnt;
  logic w_c_gnt;
  logic w_wgnt;
  logic w_last_v;
  logic w_last_o;

  // A read colliding with the write presented this cycle must wait, so the
  // read is issued only after the write has landed in the RAM.
  assign w_s_haz  = bus.s_wreq & (bus.s_raddr == bus.s_waddr);
  assign w_c_haz  = bus.s_wreq & (bus.c_raddr == bus.s_waddr);
  assign w_s_elig = bus.s_rreq & ~w_s_haz & ~reset;
  assign w_c_elig = bus.c_rreq & ~w_c_haz & ~reset;

  // On contention the requester not granted last wins.
  assign w_s_gnt  = w_s_elig & (~w_c_elig | r_lg);
  assign w_c_gnt  = w_c_elig & (~w_s_elig | ~r_lg);
  assign w_wgnt   = bus.s_wreq & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lg    <= 1'b1;
      r_wea   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 1'b0;
      r_raddr <= '0;
      r_tag_v <= '0;
      r_tag_o <= '0;
    end else begin
      r_wea <= w_wgnt;
      if (w_wgnt) begin
        r_waddr <= bus.s_waddr;
        r_wdata <= bus.s_wdata;
      end

      if (w_s_gnt) begin
        r_raddr <= bus.s_raddr;
        r_lg    <= 1'b0;
      end else if (w_c_gnt) begin
        r_raddr <= bus.c_raddr;
        r_lg    <= 1'b1;
      end

      r_tag_v <= {r_tag_v[c_NSTG-2:0], (w_s_gnt | w_c_gnt)};
      r_tag_o <= {r_tag_o[c_NSTG-2:0], w_c_gnt};
    end
  end

  // Outputs are forced low during reset so nothing leaks from the stages
  // that are about to be cleared.
  assign w_last_v     = r_tag_v[c_NSTG-1] & ~reset;
  assign w_last_o     = r_tag_o[c_NSTG-1];

  assign bus.s_rgnt   = w_s_gnt;
  assign bus.c_rgnt   = w_c_gnt;
  assign bus.s_wgnt   = w_wgnt;
  assign bus.s_rvalid = w_last_v & ~w_last_o;
  assign bus.c_rvalid = w_last_v &  w_last_o;
  assign bus.s_rdata  = w_last_v & ~w_last_o & bus.ram_rdata;
  assign bus.c_rdata  = w_last_v &  w_last_o & bus.ram_rdata;
  assign bus.ram_wea   = r_wea;
  assign bus.ram_waddr = r_waddr;
  assign bus.ram_wdata = r_wdata;
  assign bus.ram_raddr = r_raddr;
  assign bus.busy      = (|r_tag_v) & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_prime_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prime_ram_arbiter
//  Description : Testbench for prime_ram_arbiter with a behavioural flag RAM
//                (RD_LAT clocks from ram_raddr to ram_rdata, preloaded with
//                prime flags for addresses 0..255).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prime_ram_arbiter;

  localparam int AW     = 20;
  localparam int RD_LAT = 2;

  logic clk;
  logic reset;

  prime_ram_arbiter_if #(.AW(AW)) bus ();

  prime_ram_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- RAM model
  function automatic logic is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  logic              mem [256];
  logic [RD_LAT-1:0] pipe;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= is_prime(i);
    end else if (bus.ram_wea) begin
      mem[bus.ram_waddr[7:0]] <= bus.ram_wdata;
    end
    pipe <= {pipe[RD_LAT-2:0], mem[bus.ram_raddr[7:0]]};
  end
  assign bus.ram_rdata = pipe[RD_LAT-1];

  // ---------------------------------------------------------------- checking
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic srq, input logic [7:0] sa,
                       input logic crq, input logic [7:0] ca,
                       input logic wrq, input logic [7:0] wa, input logic wd);
    bus.s_rreq  = srq;
    bus.s_raddr = {12'b0, sa};
    bus.c_rreq  = crq;
    bus.c_raddr = {12'b0, ca};
    bus.s_wreq  = wrq;
    bus.s_waddr = {12'b0, wa};
    bus.s_wdata = wd;
  endtask

  typedef struct {
    logic       srq;  logic [7:0] sa;
    logic       crq;  logic [7:0] ca;
    logic       wrq;  logic [7:0] wa; logic wd;
    logic       sg;   logic cg;  logic wg;
    logic       srv;  logic sd;  logic crv; logic cd;
    logic       busy; logic wea;
    logic [7:0] raddr; logic [7:0] waddr; logic wdata;
  } vec_t;

  function automatic vec_t mk(
      input logic srq, input logic [7:0] sa, input logic crq, input logic [7:0] ca,
      input logic wrq, input logic [7:0] wa, input logic wd,
      input logic sg, input logic cg, input logic wg,
      input logic srv, input logic sd, input logic crv, input logic cd,
      input logic busy, input logic wea,
      input logic [7:0] raddr, input logic [7:0] waddr, input logic wdata);
    vec_t v;
    v.srq = srq; v.sa = sa; v.crq = crq; v.ca = ca;
    v.wrq = wrq; v.wa = wa; v.wd = wd;
    v.sg = sg; v.cg = cg; v.wg = wg;
    v.srv = srv; v.sd = sd; v.crv = crv; v.cd = cd;
    v.busy = busy; v.wea = wea;
    v.raddr = raddr; v.waddr = waddr; v.wdata = wdata;
    return v;
  endfunction

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    // Row k is cycle k after reset deasserts. Flags: 2,3,5,7,11,13 = 1.
    //               srq sa   crq ca   wrq wa  wd | sg cg wg srv sd crv cd busy wea raddr waddr wdata
    vecs[0]  = mk(1, 8'd3,  1, 8'd4,  0, 8'd0,  0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0,  8'd0,  0);
    vecs[1]  = mk(1, 8'd5,  1, 8'd4,  0, 8'd0,  0,  0, 1, 0, 0, 0, 0, 0, 1, 0, 8'd3,  8'd0,  0);
    vecs[2]  = mk(1, 8'd5,  1, 8'd6,  0, 8'd0,  0,  1, 0, 0, 0, 0, 0, 0, 1, 0, 8'd4,  8'd0,  0);
    vecs[3]  = mk(1, 8'd2,  1, 8'd6,  0, 8'd0,  0,  0, 1, 0, 1, 1, 0, 0, 1, 0, 8'd5,  8'd0,  0);
    vecs[4]  = mk(1, 8'd2,  0, 8'd0,  0, 8'd0,  0,  1, 0, 0, 0, 0, 1, 0, 1, 0, 8'd6,  8'd0,  0);
    vecs[5]  = mk(0, 8'd0,  0, 8'd0,  0, 8'd0,  0,  0, 0, 0, 1, 1, 0, 0, 1, 0, 8'd2,  8'd0,  0);
    vecs[6]  = mk(0, 8'd0,  0, 8'd0,  0, 8'd0,  0,  0, 0, 0, 0, 0, 1, 0, 1, 0, 8'd2,  8'd0,  0);
    vecs[7]  = mk(0, 8'd0,  0, 8'd0,  0, 8'd0,  0,  0, 0, 0, 1, 1, 0, 0, 1, 0, 8'd2,  8'd0,  0);
    // scanner read of 9 collides with a write of 9
    vecs[8]  = mk(0, 8'd0,  1, 8'd9,  1, 8'd9,  1,  0, 0, 1, 0, 0, 0, 0, 0, 0, 8'd2,  8'd0,  0);
    vecs[9]  = mk(0, 8'd0,  1, 8'd9,  0, 8'd0,  0,  0, 1, 0, 0, 0, 0, 0, 0, 1, 8'd2,  8'd9,  1);
    // sieve blocked by its own write even though it is favoured
    vecs[10] = mk(1, 8'd11, 1, 8'd13, 1, 8'd11, 0,  0, 1, 1, 0, 0, 0, 0, 1, 0, 8'd9,  8'd9,  1);
    vecs[11] = mk(1, 8'd11, 0, 8'd0,  0, 8'd0,  0,  1, 0, 0, 0, 0, 0, 0, 1, 1, 8'd13, 8'd11, 0);
    vecs[12] = mk(0, 8'd0,  0, 8'd0,  0, 8'd0,  0,  0, 0, 0, 0, 0, 1, 1, 1, 0, 8'd11, 8'd11, 0);
    vecs[13] = mk(0, 8'd0,  0, 8'd0,  0, 8'd0,  0,  0, 0, 0, 0, 0, 1, 1, 1, 0, 8'd11, 8'd11, 0);
    vecs[14] = mk(0, 8'd0,  0, 8'd0,  0, 8'd0,  0,  0, 0, 0, 1, 0, 0, 0, 1, 0, 8'd11, 8'd11, 0);
    // single sieve read of 7
    vecs[15] = mk(1, 8'd7,  0, 8'd0,  0, 8'd0,  0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 8'd11, 8'd11, 0);
    vecs[16] = mk(0, 8'd0,  0, 8'd0,  0, 8'd0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'd7,  8'd11, 0);
    vecs[17] = mk(0, 8'd0,  0, 8'd0,  0, 8'd0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 8'd7,  8'd11, 0);
    vecs[18] = mk(0, 8'd0,  0, 8'd0,  0, 8'd0,  0,  0, 0, 0, 1, 1, 0, 0, 1, 0, 8'd7,  8'd11, 0);
    vecs[19] = mk(0, 8'd0,  0, 8'd0,  0, 8'd0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd7,  8'd11, 0);

    // ------------------------------------------------ reset with requests held
    reset = 1'b1;
    drive(1, 8'd3, 1, 8'd4, 1, 8'd20, 1);
    @(negedge clk);
    #1;
    chk("rst_s_rgnt",   {31'b0, bus.s_rgnt},   32'd0);
    chk("rst_c_rgnt",   {31'b0, bus.c_rgnt},   32'd0);
    chk("rst_s_wgnt",   {31'b0, bus.s_wgnt},   32'd0);
    chk("rst_busy",     {31'b0, bus.busy},     32'd0);
    chk("rst_s_rvalid", {31'b0, bus.s_rvalid}, 32'd0);
    chk("rst_c_rvalid", {31'b0, bus.c_rvalid}, 32'd0);
    chk("rst_ram_wea",  {31'b0, bus.ram_wea},  32'd0);
    chk("rst_ram_raddr", {12'b0, bus.ram_raddr}, 32'd0);
    chk("rst_ram_waddr", {12'b0, bus.ram_waddr}, 32'd0);
    chk("rst_ram_wdata", {31'b0, bus.ram_wdata}, 32'd0);

    // ------------------------------------------------ table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset = 1'b0;
      drive(vecs[i].srq, vecs[i].sa, vecs[i].crq, vecs[i].ca,
            vecs[i].wrq, vecs[i].wa, vecs[i].wd);
      #1;
      chk($sformatf("r%0d_s_rgnt", i),   {31'b0, bus.s_rgnt},   {31'b0, vecs[i].sg});
      chk($sformatf("r%0d_c_rgnt", i),   {31'b0, bus.c_rgnt},   {31'b0, vecs[i].cg});
      chk($sformatf("r%0d_s_wgnt", i),   {31'b0, bus.s_wgnt},   {31'b0, vecs[i].wg});
      chk($sformatf("r%0d_s_rvalid", i), {31'b0, bus.s_rvalid}, {31'b0, vecs[i].srv});
      chk($sformatf("r%0d_s_rdata", i),  {31'b0, bus.s_rdata},  {31'b0, vecs[i].sd});
      chk($sformatf("r%0d_c_rvalid", i), {31'b0, bus.c_rvalid}, {31'b0, vecs[i].crv});
      chk($sformatf("r%0d_c_rdata", i),  {31'b0, bus.c_rdata},  {31'b0, vecs[i].cd});
      chk($sformatf("r%0d_busy", i),     {31'b0, bus.busy},     {31'b0, vecs[i].busy});
      chk($sformatf("r%0d_ram_wea", i),  {31'b0, bus.ram_wea},  {31'b0, vecs[i].wea});
      chk($sformatf("r%0d_ram_raddr", i), {12'b0, bus.ram_raddr}, {24'b0, vecs[i].raddr});
      chk($sformatf("r%0d_ram_waddr", i), {12'b0, bus.ram_waddr}, {24'b0, vecs[i].waddr});
      chk($sformatf("r%0d_ram_wdata", i), {31'b0, bus.ram_wdata}, {31'b0, vecs[i].wdata});
    end

    // ------------------------------------------------ reset with reads in flight
    // last grant was the sieve, so the scanner wins this contention
    @(negedge clk);
    drive(1, 8'd3, 1, 8'd5, 0, 8'd0, 0);
    #1;
    chk("mr0_c_rgnt", {31'b0, bus.c_rgnt}, 32'd1);
    chk("mr0_s_rgnt", {31'b0, bus.s_rgnt}, 32'd0);
    @(negedge clk);
    drive(1, 8'd3, 0, 8'd0, 0, 8'd0, 0);
    #1;
    chk("mr1_s_rgnt", {31'b0, bus.s_rgnt}, 32'd1);
    chk("mr1_busy",   {31'b0, bus.busy},   32'd1);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 8'd3, 0, 8'd0, 0, 8'd0, 0);
    #1;
    chk("mr2_s_rgnt", {31'b0, bus.s_rgnt}, 32'd0);
    chk("mr2_busy",   {31'b0, bus.busy},   32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 8'd0, 0, 8'd0, 0, 8'd0, 0);
    #1;
    chk("mr3_busy", {31'b0, bus.busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mr%0d_s_rvalid", k + 3), {31'b0, bus.s_rvalid}, 32'd0);
      chk($sformatf("mr%0d_c_rvalid", k + 3), {31'b0, bus.c_rvalid}, 32'd0);
      @(negedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
